// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response and decode handshake bundle
interface fetch_unit_if;
    logic [29:0] ic_index;
    logic        ic_en;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    // Fetch unit side: drives memory requests and the decode-facing head
    modport master (
        output ic_index,
        output ic_en,
        input  ic_rdata,
        input  ic_rvalid,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    // Environment side: the memory responder plus the decode consumer
    modport slave (
        input  ic_index,
        input  ic_en,
        output ic_rdata,
        output ic_rvalid,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with two-cycle memory shadow pipe and buffer FIFO
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         proto_err_o,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // One extra bit so count + two in-flight slots never wraps in the compare
    localparam int OW = CW + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0] pc_q, pc_d;
    logic        s1_v_q, s1_v_d;
    logic [31:0] s1_pc_q, s1_pc_d;
    logic        s2_v_q, s2_v_d;
    logic [31:0] s2_pc_q, s2_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    // Squash history: a flush one or two cycles ago means a response may still
    // arrive for a request the shadow pipe has already forgotten
    logic        sq1_q, sq1_d;
    logic        sq2_q, sq2_d;
    logic        proto_err_q, proto_err_d;

    logic [31:0] fifo_pc_q    [FIFO_DEPTH];
    logic [31:0] fifo_instr_q [FIFO_DEPTH];

    logic [OW-1:0] occ;
    logic          issue;
    logic          push;
    logic          pop;
    logic          err_set;
    logic          head_valid;

    // Credit check, handshake qualification and all next-state values
    always_comb begin
        occ        = OW'(count_q) + OW'(s1_v_q) + OW'(s2_v_q);
        issue      = !rst && !redirect_valid_i && (occ < OW'(FIFO_DEPTH));
        head_valid = (count_q != '0) && !redirect_valid_i;
        pop        = head_valid && bus.instr_ready;
        push       = bus.ic_rvalid && s2_v_q && !redirect_valid_i;
        err_set    = bus.ic_rvalid && !s2_v_q && !(redirect_valid_i || sq1_q || sq2_q);

        pc_d        = pc_q;
        s1_v_d      = 1'b0;
        s1_pc_d     = s1_pc_q;
        s2_v_d      = s1_v_q;
        s2_pc_d     = s1_pc_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sq1_d       = redirect_valid_i;
        sq2_d       = sq1_q;
        proto_err_d = proto_err_q | err_set;

        if (redirect_valid_i) begin
            pc_d     = redirect_pc_i & 32'hFFFF_FFFC;
            s2_v_d   = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (issue) begin
                s1_v_d  = 1'b1;
                s1_pc_d = pc_q;
                pc_d    = pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state; reset also opens the squash window so responses to
    // requests issued before reset are dropped quietly
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC_ALIGNED;
            s1_v_q      <= 1'b0;
            s1_pc_q     <= '0;
            s2_v_q      <= 1'b0;
            s2_pc_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sq1_q       <= 1'b1;
            sq2_q       <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            s1_v_q      <= s1_v_d;
            s1_pc_q     <= s1_pc_d;
            s2_v_q      <= s2_v_d;
            s2_pc_q     <= s2_pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sq1_q       <= sq1_d;
            sq2_q       <= sq2_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Buffer storage; contents are don't-care whenever count says empty
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc_q[wr_ptr_q]    <= s2_pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.ic_rdata;
        end
    end

    assign bus.ic_index    = pc_q[31:2];
    assign bus.ic_en       = issue;
    assign bus.instr_valid = head_valid;
    assign bus.instr_data  = head_valid ? fifo_instr_q[rd_ptr_q] : 32'h0000_0013;
    assign bus.instr_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;
    assign proto_err_o     = proto_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        redir2;
    logic [31:0] redir2_pc;
    logic        perr1, perr2;
    logic        ready1, ready2;
    logic        inj;

    fetch_unit_if b1 ();
    fetch_unit_if b2 ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .redirect_valid_i(redir), .redirect_pc_i(redir_pc),
        .proto_err_o(perr1), .bus(b1)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .redirect_valid_i(redir2), .redirect_pc_i(redir2_pc),
        .proto_err_o(perr2), .bus(b2)
    );

    // Two-cycle memory models: word i holds 0x1000_0000 + i
    logic        m1v_a = 1'b0, m2v_a = 1'b0, m1v_b = 1'b0, m2v_b = 1'b0;
    logic [29:0] m1i_a = '0, m2i_a = '0, m1i_b = '0, m2i_b = '0;
    always @(posedge clk) begin
        m1v_a <= b1.ic_en; m1i_a <= b1.ic_index; m2v_a <= m1v_a; m2i_a <= m1i_a;
        m1v_b <= b2.ic_en; m1i_b <= b2.ic_index; m2v_b <= m1v_b; m2i_b <= m1i_b;
    end
    assign b1.ic_rvalid   = m2v_a | inj;
    assign b1.ic_rdata    = 32'h1000_0000 + {2'b00, m2i_a};
    assign b1.instr_ready = ready1;
    assign b2.ic_rvalid   = m2v_b;
    assign b2.ic_rdata    = 32'h1000_0000 + {2'b00, m2i_b};
    assign b2.instr_ready = ready2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] d;
    } ent_t;
    ent_t exp1[$];
    ent_t exp2[$];
    ent_t e1, e2;
    int checks = 0;
    int fails  = 0;
    int pops1  = 0;
    int pops2  = 0;
    int en_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    task automatic push_seq(input int which, input logic [31:0] start, input int n);
        ent_t e;
        for (int k = 0; k < n; k++) begin
            e.pc = start + 32'(4 * k);
            e.d  = 32'h1000_0000 + {2'b00, e.pc[31:2]};
            if (which == 1) exp1.push_back(e);
            else exp2.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for dut: every accepted head is compared against the next expectation
    always @(negedge clk) begin
        if (b1.instr_valid && b1.instr_ready) begin
            pops1++;
            if (exp1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb1_unexpected actual_pc=%h required=none", b1.instr_pc);
            end else begin
                e1 = exp1.pop_front();
                chk("sb1_pc", b1.instr_pc, e1.pc);
                chk("sb1_data", b1.instr_data, e1.d);
            end
        end
    end

    // Monitor for dut2 (wrapping reset PC)
    always @(negedge clk) begin
        if (b2.instr_valid && b2.instr_ready) begin
            pops2++;
            if (exp2.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb2_unexpected actual_pc=%h required=none", b2.instr_pc);
            end else begin
                e2 = exp2.pop_front();
                chk("sb2_pc", b2.instr_pc, e2.pc);
                chk("sb2_data", b2.instr_data, e2.d);
            end
        end
    end

    initial begin
        rst = 1'b1; redir = 1'b0; redir_pc = '0; redir2 = 1'b0; redir2_pc = '0;
        ready1 = 1'b0; ready2 = 1'b0; inj = 1'b0;
        repeat (3) tick();

        // Reset values
        @(negedge clk);
        chk("rst_ic_en", 32'(b1.ic_en), 32'd0);
        chk("rst_ic_index", 32'(b1.ic_index), 32'd0);
        chk("rst_instr_valid", 32'(b1.instr_valid), 32'd0);
        chk("rst_instr_data", b1.instr_data, 32'h0000_0013);
        chk("rst_instr_pc", b1.instr_pc, 32'd0);
        chk("rst_proto_err", 32'(perr1), 32'd0);
        chk("rst2_ic_index", 32'(b2.ic_index), 32'h3FFF_FFFE);

        // Streaming with ready held high; dut2 wraps past 0xFFFF_FFFC
        push_seq(1, 32'h0, 16);
        push_seq(2, 32'hFFFF_FFF8, 16);
        tick();
        rst = 1'b0; ready1 = 1'b1; ready2 = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 0) chk("first_ic_en", 32'(b1.ic_en), 32'd1);
            if (c <= 3) chk("first_valid_timing", 32'(b1.instr_valid), (c == 3) ? 32'd1 : 32'd0);
            tick();
        end
        ready1 = 1'b0; ready2 = 1'b0;
        chk("stream_pops", 32'(pops1), 32'd10);
        chk("wrap_pops", 32'(pops2), 32'd10);

        // Reset mid-stream for one cycle; late responses must be dropped silently
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp1.delete(); exp2.delete();
        pops1 = 0; pops2 = 0;
        push_seq(1, 32'h0, 32);
        en_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b1.ic_en) en_cnt++;
            if (c == 2) chk("midrst_no_proto_err", 32'(perr1), 32'd0);
            if (c == 19) begin
                chk("full_valid", 32'(b1.instr_valid), 32'd1);
                chk("full_ic_en", 32'(b1.ic_en), 32'd0);
            end
            tick();
        end
        chk("full_issue_count", 32'(en_cnt), 32'd4);
        chk("full_no_pops", 32'(pops1), 32'd0);
        ready1 = 1'b1;
        repeat (12) tick();
        chk("drain_pops", 32'(pops1), 32'd12);

        // Redirect while responses are in flight and the FIFO is non-empty
        ready1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp1.delete();
        pops1 = 0;
        push_seq(1, 32'h200, 16);
        repeat (4) tick();
        redir = 1'b1; redir_pc = 32'h0000_0203; ready1 = 1'b1;
        @(negedge clk);
        chk("redir_N_valid", 32'(b1.instr_valid), 32'd0);
        chk("redir_N_ic_en", 32'(b1.ic_en), 32'd0);
        tick();
        redir = 1'b0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("redir_gap_valid", 32'(b1.instr_valid), 32'd0);
            if (k == 1) begin
                chk("redir_issue_en", 32'(b1.ic_en), 32'd1);
                chk("redir_issue_index", 32'(b1.ic_index), 32'h0000_0080);
            end
            tick();
        end
        @(negedge clk);
        chk("redir_first_valid", 32'(b1.instr_valid), 32'd1);
        chk("redir_first_pc", b1.instr_pc, 32'h0000_0200);
        chk("redir_proto_err", 32'(perr1), 32'd0);
        tick();
        repeat (4) tick();
        chk("redir_pops", 32'(pops1), 32'd5);

        // Spurious response with nothing outstanding
        ready1 = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("idle_proto_err", 32'(perr1), 32'd0);
        chk("idle_ic_en", 32'(b1.ic_en), 32'd0);
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        @(negedge clk);
        chk("proto_err_set", 32'(perr1), 32'd1);
        repeat (5) tick();
        @(negedge clk);
        chk("proto_err_sticky", 32'(perr1), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("proto_err_cleared", 32'(perr1), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
